// File: rtl/ysyx_24100029_id_ex_stage_if.sv
// ysyx_24100029_id_ex_stage_if: IDU-side and EXU-side handshake/data bundle of the ID/EX stage
interface ysyx_24100029_id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              IDU_valid;
  logic              IDU_ready;
  logic [DATA_W-1:0] IDU_pc;
  logic [DATA_W-1:0] IDU_imm;
  logic [4:0]        IDU_rd;
  logic              IDU_R_Wen;
  logic              IDU_mem_ren;
  logic [CTRL_W-1:0] IDU_ctrl;
  logic [2:0]        IDU_rs1_choice;
  logic [2:0]        IDU_rs2_choice;
  logic [DATA_W-1:0] RF_rdata1;
  logic [DATA_W-1:0] RF_rdata2;
  logic [DATA_W-1:0] EXU_fwd_data;
  logic              EXU_fwd_is_load;
  logic [DATA_W-1:0] WBU_fwd_data;
  logic [DATA_W-1:0] MEM_rdata;
  logic              MEM_rdata_valid;
  logic [DATA_W-1:0] MEM_fwd_data;
  logic              EXU_valid;
  logic              EXU_ready;
  logic [DATA_W-1:0] EXU_pc;
  logic [DATA_W-1:0] EXU_src1;
  logic [DATA_W-1:0] EXU_src2;
  logic [DATA_W-1:0] EXU_imm;
  logic [4:0]        EXU_rd;
  logic              EXU_R_Wen;
  logic              EXU_mem_ren;
  logic [CTRL_W-1:0] EXU_ctrl;
  modport slave (
    input  IDU_valid, IDU_pc, IDU_imm, IDU_rd, IDU_R_Wen, IDU_mem_ren, IDU_ctrl,
           IDU_rs1_choice, IDU_rs2_choice, RF_rdata1, RF_rdata2, EXU_fwd_data,
           EXU_fwd_is_load, WBU_fwd_data, MEM_rdata, MEM_rdata_valid, MEM_fwd_data, EXU_ready,
    output IDU_ready, EXU_valid, EXU_pc, EXU_src1, EXU_src2, EXU_imm, EXU_rd,
           EXU_R_Wen, EXU_mem_ren, EXU_ctrl
  );
  modport master (
    output IDU_valid, IDU_pc, IDU_imm, IDU_rd, IDU_R_Wen, IDU_mem_ren, IDU_ctrl,
           IDU_rs1_choice, IDU_rs2_choice, RF_rdata1, RF_rdata2, EXU_fwd_data,
           EXU_fwd_is_load, WBU_fwd_data, MEM_rdata, MEM_rdata_valid, MEM_fwd_data, EXU_ready,
    input  IDU_ready, EXU_valid, EXU_pc, EXU_src1, EXU_src2, EXU_imm, EXU_rd,
           EXU_R_Wen, EXU_mem_ren, EXU_ctrl
  );
endinterface

// File: rtl/ysyx_24100029_id_ex_stage.sv
// ysyx_24100029_id_ex_stage: ID/EX pipeline register with operand forwarding mux, load-use stall and stall counter
module ysyx_24100029_id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  ysyx_24100029_id_ex_stage_if.slave bus,
  output logic [CNT_W-1:0]     stall_cnt
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] pc_q, src1_q, src2_q, imm_q, src1_d, src2_d;
  logic [4:0]        rd_q;
  logic              wen_q, ren_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hazard, space, accept;
  function automatic logic [DATA_W-1:0] pick(input logic [2:0] c, input logic [DATA_W-1:0] rf,
                                             exu, wbu, memr, memf);
    return c == 3'b001 ? exu : c == 3'b010 ? wbu : c == 3'b011 ? memr : c == 3'b100 ? memf : rf;
  endfunction
  always_comb begin
    src1_d = pick(bus.IDU_rs1_choice, bus.RF_rdata1, bus.EXU_fwd_data, bus.WBU_fwd_data,
                  bus.MEM_rdata, bus.MEM_fwd_data);
    src2_d = pick(bus.IDU_rs2_choice, bus.RF_rdata2, bus.EXU_fwd_data, bus.WBU_fwd_data,
                  bus.MEM_rdata, bus.MEM_fwd_data);
    hazard = bus.IDU_valid &&
             (((bus.IDU_rs1_choice == 3'b011 || bus.IDU_rs2_choice == 3'b011) && !bus.MEM_rdata_valid) ||
              ((bus.IDU_rs1_choice == 3'b001 || bus.IDU_rs2_choice == 3'b001) && bus.EXU_fwd_is_load));
    space = state_q == EMPTY || bus.EXU_ready;
    bus.IDU_ready = space && !hazard && !flush && !rst;
    accept = bus.IDU_valid && bus.IDU_ready;
    state_d = flush ? EMPTY : (accept || (state_q == FULL && !bus.EXU_ready)) ? FULL : EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      pc_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q   <= bus.IDU_pc;
        src1_q <= src1_d;
        src2_q <= src2_d;
        imm_q  <= bus.IDU_imm;
        rd_q   <= bus.IDU_rd;
        wen_q  <= bus.IDU_R_Wen;
        ren_q  <= bus.IDU_mem_ren;
        ctrl_q <= bus.IDU_ctrl;
      end
      // only cycles where the stage could have taken the instruction count as load-use stalls
      if (hazard && space && !flush && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign bus.EXU_valid   = state_q == FULL;
  assign bus.EXU_pc      = pc_q;
  assign bus.EXU_src1    = src1_q;
  assign bus.EXU_src2    = src2_q;
  assign bus.EXU_imm     = imm_q;
  assign bus.EXU_rd      = rd_q;
  assign bus.EXU_R_Wen   = wen_q;
  assign bus.EXU_mem_ren = ren_q;
  assign bus.EXU_ctrl    = ctrl_q;
  assign stall_cnt       = cnt_q;
endmodule
